// File: rtl/text_banner_pkg.sv
// rtl/text_banner_pkg.sv - shared constants and FSM encoding for the text banner
package text_banner_pkg;

    localparam logic [1:0] MSG_CRASH    = 2'd0;
    localparam logic [1:0] MSG_GAMEOVER = 2'd1;
    localparam logic [1:0] MSG_READY    = 2'd2;
    localparam logic [1:0] MSG_PAUSED   = 2'd3;

    localparam int MAX_CHARS = 10;

    // Font ROM character addresses (7-bit ASCII); spaces/padding map to blank glyph 0
    localparam logic [6:0] CH_BLANK = 7'h00;
    localparam logic [6:0] CH_A_UC  = 7'h41;
    localparam logic [6:0] CH_C_UC  = 7'h43;
    localparam logic [6:0] CH_D_UC  = 7'h44;
    localparam logic [6:0] CH_E_UC  = 7'h45;
    localparam logic [6:0] CH_G_UC  = 7'h47;
    localparam logic [6:0] CH_M_UC  = 7'h4D;
    localparam logic [6:0] CH_O_UC  = 7'h4F;
    localparam logic [6:0] CH_P_UC  = 7'h50;
    localparam logic [6:0] CH_R_UC  = 7'h52;
    localparam logic [6:0] CH_S_UC  = 7'h53;
    localparam logic [6:0] CH_U_UC  = 7'h55;
    localparam logic [6:0] CH_V_UC  = 7'h56;
    localparam logic [6:0] CH_Y_UC  = 7'h59;
    localparam logic [6:0] CH_A_LC  = 7'h61;
    localparam logic [6:0] CH_H_LC  = 7'h68;
    localparam logic [6:0] CH_R_LC  = 7'h72;
    localparam logic [6:0] CH_S_LC  = 7'h73;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REVEAL = 2'd1,
        HOLD   = 2'd2
    } state_e;

endpackage

// File: rtl/text_banner_if.sv
// rtl/text_banner_if.sv - pixel-position in / font-lookup out bundle of the banner
// Ports: pix_x/pix_y from the sync counters; text_on, bit_addr, rom_addr toward font ROM / RGB mux.
interface text_banner_if;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        text_on;
    logic [2:0]  bit_addr;
    logic [10:0] rom_addr;

    modport master (output pix_x, pix_y, input text_on, bit_addr, rom_addr);
    modport slave  (input pix_x, pix_y, output text_on, bit_addr, rom_addr);
endinterface

// File: rtl/text_banner_msg_rom.sv
// rtl/text_banner_msg_rom.sv - combinational message table: (msg, col) -> (char_addr, len)
// Ports: msg_i message select, col_i char column; char_addr_o glyph (0 outside len), len_o length.
module text_msg_rom
    import text_banner_pkg::*;
(
    input  logic [1:0] msg_i,
    input  logic [3:0] col_i,
    output logic [6:0] char_addr_o,
    output logic [3:0] len_o
);
    always_comb begin
        char_addr_o = CH_BLANK;
        len_o       = 4'd0;
        case (msg_i)
            MSG_CRASH: begin
                len_o = 4'd5;
                case (col_i)
                    4'd0: char_addr_o = CH_C_UC;
                    4'd1: char_addr_o = CH_R_LC;
                    4'd2: char_addr_o = CH_A_LC;
                    4'd3: char_addr_o = CH_S_LC;
                    4'd4: char_addr_o = CH_H_LC;
                    default: char_addr_o = CH_BLANK;
                endcase
            end
            MSG_GAMEOVER: begin
                len_o = 4'd9;
                case (col_i)
                    4'd0: char_addr_o = CH_G_UC;
                    4'd1: char_addr_o = CH_A_UC;
                    4'd2: char_addr_o = CH_M_UC;
                    4'd3: char_addr_o = CH_E_UC;
                    4'd5: char_addr_o = CH_O_UC;
                    4'd6: char_addr_o = CH_V_UC;
                    4'd7: char_addr_o = CH_E_UC;
                    4'd8: char_addr_o = CH_R_UC;
                    default: char_addr_o = CH_BLANK;
                endcase
            end
            MSG_READY: begin
                len_o = 4'd5;
                case (col_i)
                    4'd0: char_addr_o = CH_R_UC;
                    4'd1: char_addr_o = CH_E_UC;
                    4'd2: char_addr_o = CH_A_UC;
                    4'd3: char_addr_o = CH_D_UC;
                    4'd4: char_addr_o = CH_Y_UC;
                    default: char_addr_o = CH_BLANK;
                endcase
            end
            default: begin
                len_o = 4'd6;
                case (col_i)
                    4'd0: char_addr_o = CH_P_UC;
                    4'd1: char_addr_o = CH_A_UC;
                    4'd2: char_addr_o = CH_U_UC;
                    4'd3: char_addr_o = CH_S_UC;
                    4'd4: char_addr_o = CH_E_UC;
                    4'd5: char_addr_o = CH_D_UC;
                    default: char_addr_o = CH_BLANK;
                endcase
            end
        endcase
    end
endmodule

// File: rtl/text_banner.sv
// rtl/text_banner.sv - scaled text banner with typewriter reveal and blinking hold
// Ports: clk, reset (sync, active-high), enable, msg_sel, refr_tick (per-frame pulse),
//        pix (slave bundle: pix_x/pix_y in, text_on/bit_addr/rom_addr out, 1-cycle latency),
//        done (reveal complete).
module text_banner
    import text_banner_pkg::*;
#(
    parameter int X0            = 160,
    parameter int Y0            = 128,
    parameter int SX_LOG2       = 2,
    parameter int SY_LOG2       = 2,
    parameter int REVEAL_FRAMES = 6,
    parameter int BLINK_FRAMES  = 30
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [1:0]    msg_sel,
    input  logic          refr_tick,
    text_banner_if.slave  pix,
    output logic          done
);
    localparam int FMAX = (REVEAL_FRAMES > BLINK_FRAMES) ? REVEAL_FRAMES : BLINK_FRAMES;
    localparam int FW   = (FMAX < 1) ? 1 : $clog2(FMAX + 1);
    localparam logic [FW-1:0] RF_LAST = FW'(REVEAL_FRAMES - 1);
    localparam logic [FW-1:0] BF_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [10:0]   X0_W    = 11'(X0);
    localparam logic [10:0]   Y0_W    = 11'(Y0);
    localparam logic [10:0]   H_W     = 11'(16 << SY_LOG2);

    state_e        state_q, state_d;
    logic [3:0]    shown_q, shown_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          blink_q, blink_d;
    logic [1:0]    msg_q, msg_d;
    logic          text_on_q, text_on_d;
    logic [2:0]    bit_addr_q;
    logic [10:0]   rom_addr_q;

    logic [10:0] dx, dy, col_full;
    logic [2:0]  bit_idx;
    logic [3:0]  row, col_sel, len;
    logic [6:0]  char_addr;
    logic        in_win, restart;

    // Pixels left/above the origin wrap to large dx/dy and fall out via the range tests
    assign dx       = {1'b0, pix.pix_x} - X0_W;
    assign dy       = {1'b0, pix.pix_y} - Y0_W;
    assign col_full = dx >> (3 + SX_LOG2);
    assign bit_idx  = dx[SX_LOG2+2:SX_LOG2];
    assign row      = dy[SY_LOG2+3:SY_LOG2];
    // Far columns are clamped to an index beyond every message so the ROM returns blank
    assign col_sel  = (col_full < 11'(MAX_CHARS)) ? col_full[3:0] : 4'(MAX_CHARS);

    // Lookups follow the message that will be latched at this edge
    text_msg_rom u_rom (
        .msg_i       (msg_d),
        .col_i       (col_sel),
        .char_addr_o (char_addr),
        .len_o       (len)
    );

    assign restart = enable && (state_q != IDLE) && (msg_sel != msg_q);

    always_comb begin
        msg_d = msg_q;
        if (enable && ((state_q == IDLE) || (msg_sel != msg_q))) begin
            msg_d = msg_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shown_q     <= 4'd0;
            frame_cnt_q <= '0;
            blink_q     <= 1'b1;
            msg_q       <= 2'd0;
            text_on_q   <= 1'b0;
            bit_addr_q  <= 3'd0;
            rom_addr_q  <= 11'd0;
        end else begin
            state_q     <= state_d;
            shown_q     <= shown_d;
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
            msg_q       <= msg_d;
            text_on_q   <= text_on_d;
            bit_addr_q  <= bit_idx;
            rom_addr_q  <= {char_addr, row};
        end
    end

    // Next state: enable low dominates, then a message change (which swallows any tick)
    always_comb begin
        state_d     = state_q;
        shown_d     = shown_q;
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (!enable) begin
            state_d     = IDLE;
            shown_d     = 4'd0;
            frame_cnt_d = '0;
            blink_d     = 1'b1;
        end else if (state_q == IDLE || restart) begin
            frame_cnt_d = '0;
            blink_d     = 1'b1;
            if (REVEAL_FRAMES == 0) begin
                state_d = HOLD;
                shown_d = len;
            end else begin
                state_d = REVEAL;
                shown_d = 4'd0;
            end
        end else if (state_q == REVEAL) begin
            if (refr_tick) begin
                if (frame_cnt_q == RF_LAST) begin
                    frame_cnt_d = '0;
                    shown_d     = shown_q + 4'd1;
                    if (shown_q + 4'd1 >= len) begin
                        state_d = HOLD;
                        shown_d = len;
                        blink_d = 1'b1;
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q + FW'(1);
                end
            end
        end else if (state_q == HOLD) begin
            if (BLINK_FRAMES > 0 && refr_tick) begin
                if (frame_cnt_q == BF_LAST) begin
                    frame_cnt_d = '0;
                    blink_d     = ~blink_q;
                end else begin
                    frame_cnt_d = frame_cnt_q + FW'(1);
                end
            end
        end
    end

    // Visibility is judged against the state as it stands after this edge
    always_comb begin
        in_win    = ({1'b0, pix.pix_x} >= X0_W) && ({1'b0, pix.pix_y} >= Y0_W) &&
                    (dy < H_W) && (col_full < {7'd0, len});
        text_on_d = in_win && (col_full < {7'd0, shown_d}) && (char_addr != CH_BLANK) &&
                    (state_d != IDLE) && blink_d;
        done      = (state_q == HOLD);
    end

    assign pix.text_on  = text_on_q;
    assign pix.bit_addr = bit_addr_q;
    assign pix.rom_addr = rom_addr_q;
endmodule
